fpu_div_issue: RTL and testbench

Operand issue stage directly upstream of the FP32 divider `fpu_div_RTL`. It accepts IEEE-754 single-precision operand pairs from the requester over a valid/ready handshake and buffers them in a small FIFO. It dispatches one pair at a time to the divider, waits for the divider's completion, and returns each quotient downstream with a sequence tag.

---
 rtl/fpu_div_issue.sv | 169 ++++++++++++++++
 tb/tb_fpu_div_issue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_div_issue.sv
// Operand issue stage for the FP32 divider: queues operand pairs, runs one divide at a time, tags results.
// Define FPU_DIV_ISSUE_BYPASS_EN to resolve NaN, 0/0, inf/inf and x/0 locally without using the divider.
module fpu_div_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic [31:0]      div_din1,
    output logic [31:0]      div_din2,
    output logic             div_valid,
    input  logic [31:0]      div_result,
    input  logic             div_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_bypass
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [TAG_W-1:0] TAG_ONE = 1;

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, HOLD} state_t;

    logic [31:0]      memA_q   [DEPTH];
    logic [31:0]      memB_q   [DEPTH];
    logic [TAG_W-1:0] memTag_q [DEPTH];
    logic [AW:0]      wrPtr_q, rdPtr_q;
    logic [TAG_W-1:0] inTag_q;

    state_t           state_q;
    logic [31:0]      din1_q, din2_q, result_q;
    logic [TAG_W-1:0] tag_q;
    logic             divValid_q, outValid_q, bypass_q;

    logic             full, empty, push, pop;
    logic [31:0]      headA, headB;
    logic [TAG_W-1:0] headTag;
    logic             special;
    logic [31:0]      specialResult;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && !empty;

    assign headA   = memA_q[rdPtr_q[AW-1:0]];
    assign headB   = memB_q[rdPtr_q[AW-1:0]];
    assign headTag = memTag_q[rdPtr_q[AW-1:0]];

`ifdef FPU_DIV_ISSUE_BYPASS_EN
    logic aNan, bNan, aInf, bInf, aZero, bZero;
    assign aNan  = (headA[30:23] == 8'hFF) && (headA[22:0] != '0);
    assign bNan  = (headB[30:23] == 8'hFF) && (headB[22:0] != '0);
    assign aInf  = (headA[30:23] == 8'hFF) && (headA[22:0] == '0);
    assign bInf  = (headB[30:23] == 8'hFF) && (headB[22:0] == '0);
    assign aZero = (headA[30:0] == '0);
    assign bZero = (headB[30:0] == '0);

    always_comb begin
        special       = 1'b0;
        specialResult = '0;
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            special       = 1'b1;
            specialResult = 32'h7FC00000;
        end else if (bZero) begin
            special       = 1'b1;
            specialResult = {headA[31] ^ headB[31], 31'h7F800000};
        end
    end
`else
    assign special       = 1'b0;
    assign specialResult = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            inTag_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
                inTag_q <= inTag_q + TAG_ONE;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memA_q[wrPtr_q[AW-1:0]]   <= in_a;
            memB_q[wrPtr_q[AW-1:0]]   <= in_b;
            memTag_q[wrPtr_q[AW-1:0]] <= inTag_q;
        end
    end

    // ARM spends one cycle ignoring div_ready so a level left over from the previous divide is never captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            din1_q     <= '0;
            din2_q     <= '0;
            divValid_q <= 1'b0;
            result_q   <= '0;
            tag_q      <= '0;
            outValid_q <= 1'b0;
            bypass_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        tag_q    <= headTag;
                        bypass_q <= special;
                        if (special) begin
                            result_q   <= specialResult;
                            outValid_q <= 1'b1;
                            state_q    <= HOLD;
                        end else begin
                            din1_q     <= headA;
                            din2_q     <= headB;
                            divValid_q <= 1'b1;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    divValid_q <= 1'b0;
                    state_q    <= ARM;
                end
                ARM: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (div_ready) begin
                        result_q   <= div_result;
                        outValid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_din1   = din1_q;
    assign div_din2   = din2_q;
    assign div_valid  = divValid_q;
    assign out_valid  = outValid_q;
    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign out_bypass = bypass_q;

endmodule

// File: tb/tb_fpu_div_issue.sv
// Directed self-checking bench for fpu_div_issue with a behavioural divider stub.
module tb_fpu_div_issue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [31:0]      in_a, in_b;
    logic [31:0]      div_din1, div_din2, div_result;
    logic             div_valid, div_ready;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_bypass;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_div_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_din1(div_din1), .div_din2(div_din2), .div_valid(div_valid),
        .div_result(div_result), .div_ready(div_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_bypass(out_bypass)
    );

    logic [31:0] pairA [6] = '{32'h40600000, 32'h40E00000, 32'h41000000, 32'h40400000, 32'h41200000, 32'h41100000};
    logic [31:0] pairB [6] = '{32'h3FE00000, 32'h40000000, 32'h40000000, 32'h3F800000, 32'h40A00000, 32'h40400000};
    logic [31:0] pairQ [6] = '{32'h40000000, 32'h40600000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h40400000};

    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h3F000000;
            {32'h40600000, 32'h3FE00000}: return 32'h40000000;
            {32'h40E00000, 32'h40000000}: return 32'h40600000;
            {32'h41000000, 32'h40000000}: return 32'h40800000;
            {32'h40400000, 32'h3F800000}: return 32'h40400000;
            {32'h41200000, 32'h40A00000}: return 32'h40000000;
            {32'h41100000, 32'h40400000}: return 32'h40400000;
            default:                      return a ^ b ^ 32'hA5A5A5A5;
        endcase
    endfunction

    // Divider stub: busy divLat cycles after sampling the start, then a registered result; ready is held until the next start.
    int          divLat = 5;
    bit          lateDrop = 1'b0;
    int          cnt;
    logic        dropPending;
    logic [31:0] opA, opB;

    always @(posedge clk) begin
        if (reset) begin
            div_ready   <= 1'b0;
            div_result  <= '0;
            cnt         <= 0;
            dropPending <= 1'b0;
        end else begin
            if (dropPending) begin
                div_ready   <= 1'b0;
                dropPending <= 1'b0;
            end
            if (div_valid) begin
                opA <= div_din1;
                opB <= div_din2;
                cnt <= divLat + 1;
                if (lateDrop) dropPending <= 1'b1;
                else          div_ready   <= 1'b0;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    div_ready  <= 1'b1;
                    div_result <= quot(opA, opB);
                end
            end
        end
    end

    int               cyc = 0;
    int               pulseCount = 0;
    int               pulseCyc = 0;
    int               riseCyc = 0;
    logic             outValidPrev = 1'b0;
    logic [31:0]      lastDin1, lastDin2;
    logic [31:0]      qRes [$];
    logic [TAG_W-1:0] qTag [$];
    logic             qByp [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (div_valid === 1'b1) begin
            pulseCount++;
            pulseCyc = cyc;
            lastDin1 = div_din1;
            lastDin2 = div_din2;
        end
        if (out_valid === 1'b1 && outValidPrev !== 1'b1) riseCyc = cyc;
        outValidPrev = out_valid;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            qRes.push_back(out_result);
            qTag.push_back(out_tag);
            qByp.push_back(out_bypass);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string prefix);
        checkOutput({prefix, "_div_valid"}, 32'(div_valid), 32'h0);
        checkOutput({prefix, "_din1"}, div_din1, 32'h0);
        checkOutput({prefix, "_din2"}, div_din2, 32'h0);
        checkOutput({prefix, "_out_valid"}, 32'(out_valid), 32'h0);
        checkOutput({prefix, "_out_result"}, out_result, 32'h0);
        checkOutput({prefix, "_out_tag"}, 32'(out_tag), 32'h0);
        checkOutput({prefix, "_out_bypass"}, 32'(out_bypass), 32'h0);
    endtask

    task automatic resetDut(input string prefix);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput({prefix, "_in_ready"}, 32'(in_ready), 32'h0);
        checkResetValues(prefix);
        @(posedge clk);
        #1;
        reset = 1'b0;
        qRes.delete();
        qTag.delete();
        qByp.delete();
        pulseCount = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) checkOutput("push_timeout", 32'h0, 32'h1);
    endtask

    task automatic waitOutputs(input int n, input int budget);
        for (int i = 0; i < budget && qRes.size() < n; i++) @(negedge clk);
        if (qRes.size() < n) checkOutput("output_timeout", 32'(qRes.size()), 32'(n));
    endtask

    task automatic checkQueued(input string prefix, input int i, input logic [31:0] res,
                               input logic [TAG_W-1:0] tag, input logic byp);
        if (i < qRes.size()) begin
            checkOutput($sformatf("%s%0d_result", prefix, i), qRes[i], res);
            checkOutput($sformatf("%s%0d_tag", prefix, i), 32'(qTag[i]), 32'(tag));
            checkOutput($sformatf("%s%0d_bypass", prefix, i), 32'(qByp[i]), 32'(byp));
        end else begin
            checkOutput($sformatf("%s%0d_missing", prefix, i), 32'(qRes.size()), 32'(i + 1));
        end
    endtask

    logic [31:0] bypA [5] = '{32'h00000001, 32'h7FC00000, 32'hFF800000, 32'hBF800000, 32'h00000000};
    logic [31:0] bypB [5] = '{32'h00000000, 32'h3F800000, 32'h7F800000, 32'h00000000, 32'h80000000};
    logic [31:0] bypQ [5] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};

    initial begin
        int  idx;
        bit  acc;
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;

        // Single operation: one start pulse, quotient 8 cycles after it.
        resetDut("rst0");
        applyStimulus(32'h3F800000, 32'h40000000);
        waitOutputs(1, 100);
        repeat (5) @(negedge clk);
        checkOutput("single_pulses", 32'(pulseCount), 32'h1);
        checkOutput("single_din1", lastDin1, 32'h3F800000);
        checkOutput("single_din2", lastDin2, 32'h40000000);
        checkOutput("single_latency", 32'(riseCyc - pulseCyc), 32'h8);
        checkQueued("single", 0, 32'h3F000000, '0, 1'b0);

        // Back-to-back fill with the consumer stalled, then drain.
        resetDut("rst1");
        out_ready = 1'b0;
        idx = 0;
        in_a = pairA[0];
        in_b = pairB[0];
        in_valid = 1'b1;
        repeat (14) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc && idx < 6) begin
                idx++;
                if (idx < 6) begin in_a = pairA[idx]; in_b = pairB[idx]; end
                else in_valid = 1'b0;
            end
        end
        checkOutput("fill_accepted", 32'(idx), 32'h5);
        checkOutput("fill_in_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 300 && idx < 6; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        waitOutputs(6, 400);
        for (int i = 0; i < 6; i++) checkQueued("fill", i, pairQ[i], TAG_W'(i), 1'b0);

        // Divider keeps ready high into the ARM cycle; stale results must not be captured.
        resetDut("rst2");
        lateDrop = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(pairA[i], pairB[i]);
        waitOutputs(3, 200);
        for (int i = 0; i < 3; i++) checkQueued("held", i, pairQ[i], TAG_W'(i), 1'b0);
        lateDrop = 1'b0;

        // Special-case operands.
        resetDut("rst3");
        for (int i = 0; i < 5; i++) applyStimulus(bypA[i], bypB[i]);
        waitOutputs(5, 200);
        repeat (3) @(negedge clk);
`ifdef FPU_DIV_ISSUE_BYPASS_EN
        checkOutput("byp_pulses", 32'(pulseCount), 32'h0);
        for (int i = 0; i < 5; i++) checkQueued("byp", i, bypQ[i], TAG_W'(i), 1'b1);
`else
        checkOutput("byp_pulses", 32'(pulseCount), 32'h5);
        for (int i = 0; i < 5; i++) checkQueued("byp", i, quot(bypA[i], bypB[i]), TAG_W'(i), 1'b0);
`endif

        // One-cycle reset while waiting on the divider with two pairs queued.
        resetDut("rst4");
        divLat = 20;
        for (int i = 0; i < 3; i++) applyStimulus(pairA[i], pairB[i]);
        for (int i = 0; i < 50 && pulseCount < 1; i++) @(negedge clk);
        checkOutput("mid_pulse_seen", 32'(pulseCount), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("mid");
        repeat (40) @(negedge clk);
        checkOutput("mid_no_output", 32'(qRes.size()), 32'h0);
        checkOutput("mid_no_dispatch", 32'(pulseCount), 32'h1);
        divLat = 5;
        applyStimulus(pairA[3], pairB[3]);
        waitOutputs(1, 100);
        checkQueued("mid_after", 0, pairQ[3], '0, 1'b0);

        // Tag wrap after 16 operations.
        resetDut("rst5");
        for (int i = 0; i < 17; i++) applyStimulus(32'h3F800000, 32'h40000000);
        waitOutputs(17, 600);
        checkQueued("wrap", 15, 32'h3F000000, TAG_W'(15), 1'b0);
        checkQueued("wrap", 16, 32'h3F000000, TAG_W'(0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "[TB] global time limit");
    end

endmodule
